arashi_wrr_arbiter: RTL and testbench
=====================================

ARASHI_WRR_ARBITER -- requirements
Module: arashi_wrr_arbiter

Interface
REQ-001 SHALL have parameter THREAD_NUM_WIDTH, default 2, log2 of thread count; legal range 1..5; THREAD_NUM = 1 << THREAD_NUM_WIDTH.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, width of each per-thread weight.
REQ-003 SHALL have port clk  input  1  clock; all state on posedge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port avail  input  THREAD_NUM  per-thread request; bit i = thread i ready to issue.
REQ-006 SHALL have port weight  input  THREAD_NUM*WEIGHT_WIDTH  per-thread beat quota; thread i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-007 SHALL have port gnt_valid  output  1  grant offered.
REQ-008 SHALL have port gnt_ready  input  1  consumer accepts current grant beat.
REQ-009 SHALL have port gnt_id  output  THREAD_NUM_WIDTH  granted thread.
REQ-010 SHALL have port gnt_last  output  1  current beat is the final beat of this thread's quota.

Function
REQ-011 SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1); all outputs registered.
REQ-012 SHALL keep pointer ptr = last granted thread; search order is ptr+1, ptr+2, ... modulo THREAD_NUM; first set avail bit wins.
REQ-013 IDLE -> GRANT: when |avail=1, next cycle gnt_valid=1, gnt_id=search winner; latency exactly 1 cycle.
REQ-014 On grant start SHALL load credit = weight[winner]; weight 0 treated as 1.
REQ-015 gnt_last SHALL equal (credit==1) while gnt_valid=1; 0 otherwise.
REQ-016 While gnt_valid=1 and gnt_ready=0, gnt_id, gnt_last, credit SHALL hold; no retraction even if avail[gnt_id] drops.
REQ-017 On accept (gnt_valid&gnt_ready) with credit>1 and avail[gnt_id]=1: credit-1, same gnt_id, gnt_valid stays 1.
REQ-018 On accept with credit==1 or avail[gnt_id]=0: ptr<=gnt_id; search from gnt_id+1 using current avail; winner found -> back-to-back grant next cycle with fresh credit; none -> IDLE.
REQ-019 Single requester: after quota end, search wraps to same thread; SHALL re-grant it back-to-back with reloaded credit.
REQ-020 Weight changes during a grant SHALL take effect only at next grant start.
REQ-021 Credit counter SHALL be WEIGHT_WIDTH bits, never underflow.

Reset
REQ-022 rstn=0 at posedge SHALL force: state IDLE, gnt_valid=0, gnt_id=0, gnt_last=0, credit=0, ptr=THREAD_NUM-1 (first search starts at thread 0).
REQ-023 Reset mid-grant SHALL abandon the grant; no beat completes in the reset cycle regardless of gnt_ready.
REQ-024 First grant after reset release SHALL follow REQ-013 from ptr=THREAD_NUM-1.

Configuration
REQ-025 Macro ARASHI_ARB_LOCK_EN SHALL add input port lock (1 bit).
REQ-026 With ARASHI_ARB_LOCK_EN: accept with lock=1 SHALL keep gnt_id and not decrement credit, independent of credit and avail; grant ends per REQ-018 on first accept with lock=0.
REQ-027 Without ARASHI_ARB_LOCK_EN: no lock port; behaviour exactly REQ-011..REQ-024.

Verification (THREAD_NUM_WIDTH=2, WEIGHT_WIDTH=4)
REQ-028 Reset then avail=4'b1111, weights all 1, gnt_ready=1 -> gnt_id 0,1,2,3,0 on consecutive cycles, gnt_last=1 every beat.
REQ-029 avail=4'b0101, weight[0]=3, weight[2]=2, gnt_ready=1 -> ids 0,0,0,2,2,0; gnt_last on 3rd and 5th beat.
REQ-030 Grant id=1 credit 2, gnt_ready=0 for 4 cycles while avail[1] drops -> gnt_id=1, gnt_valid=1 held; on accept grant ends, next search from 2.
REQ-031 avail=4'b1000 only, weight[3]=0 -> id 3 every cycle, gnt_last=1 each beat; avail->0 -> gnt_valid=0 after last accept.
REQ-032 rstn=0 during id=2 grant with gnt_ready=1 -> next cycle gnt_valid=0, gnt_id=0; with avail=4'b0100 after release -> id 2 one cycle later.
REQ-033 ARASHI_ARB_LOCK_EN, weight[1]=1, lock=1 for 5 accepts -> id 1 for 5 beats; lock=0 accept -> next thread granted.

Source files
------------

// File: rtl/arashi_wrr_arbiter.sv
// Weighted round-robin arbiter: grants one thread at a time for up to weight[i] beats.
// Optional macro ARASHI_ARB_LOCK_EN adds a 'lock' input that pins the current grant.
module arashi_wrr_arbiter #(
  parameter  int THREAD_NUM_WIDTH = 2,
  parameter  int WEIGHT_WIDTH     = 4,
  localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [THREAD_NUM-1:0]              avail,
  input  logic [THREAD_NUM*WEIGHT_WIDTH-1:0] weight,
`ifdef ARASHI_ARB_LOCK_EN
  input  logic                               lock,
`endif
  output logic                               gnt_valid,
  input  logic                               gnt_ready,
  output logic [THREAD_NUM_WIDTH-1:0]        gnt_id,
  output logic                               gnt_last
);

  // state | meaning
  // IDLE  | no grant offered, searching avail every cycle
  // GRANT | gnt_id offered, credit beats left in its quota
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = WEIGHT_WIDTH'(1);

  state_t                      state;
  logic [WEIGHT_WIDTH-1:0]     credit;
  logic [THREAD_NUM_WIDTH-1:0] ptr;

  logic [THREAD_NUM_WIDTH-1:0] search_base;
  logic [THREAD_NUM_WIDTH-1:0] search_idx;
  logic [THREAD_NUM_WIDTH-1:0] win_id;
  logic                        win_found;
  logic [WEIGHT_WIDTH-1:0]     win_weight;
  logic [WEIGHT_WIDTH-1:0]     win_credit;
  logic                        lock_hold;
  logic                        accept;

`ifdef ARASHI_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // In IDLE the search starts after ptr; at quota end it starts after the current grant.
  assign search_base = gnt_valid ? gnt_id : ptr;
  assign accept      = gnt_valid & gnt_ready;

  // Walk offsets from farthest to nearest so the nearest set bit is the one kept;
  // offset THREAD_NUM wraps to the base itself, letting a lone requester be re-granted.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    search_idx = '0;
    for (int i = THREAD_NUM; i >= 1; i--) begin
      search_idx = search_base + THREAD_NUM_WIDTH'(i);
      if (avail[search_idx]) begin
        win_found = 1'b1;
        win_id    = search_idx;
      end
    end
  end

  assign win_weight = weight[win_id*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign win_credit = (win_weight == '0) ? CREDIT_ONE : win_weight;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      gnt_last  <= 1'b0;
      credit    <= '0;
      ptr       <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            credit    <= win_credit;
            gnt_last  <= (win_credit == CREDIT_ONE);
          end
        end
        GRANT: begin
          if (accept && !lock_hold) begin
            if ((credit > CREDIT_ONE) && avail[gnt_id]) begin
              credit   <= credit - CREDIT_ONE;
              gnt_last <= ((credit - CREDIT_ONE) == CREDIT_ONE);
            end else begin
              ptr <= gnt_id;
              if (win_found) begin
                gnt_id   <= win_id;
                credit   <= win_credit;
                gnt_last <= (win_credit == CREDIT_ONE);
              end else begin
                state     <= IDLE;
                gnt_valid <= 1'b0;
                gnt_last  <= 1'b0;
                credit    <= '0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
          gnt_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arashi_wrr_arbiter.sv
// Scoreboard bench for arashi_wrr_arbiter: directed scenarios plus random traffic
// against a behavioural model of the weighted round-robin rules.
module tb_arashi_wrr_arbiter;
  localparam int TW = 2;
  localparam int WW = 4;
  localparam int N  = 1 << TW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  avail = '0;
  logic [N*WW-1:0] weight = '0;
  logic          gnt_ready = 1'b0;
  logic          gnt_valid;
  logic [TW-1:0] gnt_id;
  logic          gnt_last;
`ifdef ARASHI_ARB_LOCK_EN
  logic          lock = 1'b0;
`endif

  always #5 clk = ~clk;

  arashi_wrr_arbiter #(.THREAD_NUM_WIDTH(TW), .WEIGHT_WIDTH(WW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .avail     (avail),
    .weight    (weight),
`ifdef ARASHI_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_id    (gnt_id),
    .gnt_last  (gnt_last)
  );

  typedef struct {
    bit valid;
    int id;
    bit last;
    bit cmp_id;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: who holds the grant, how many beats remain, who was granted last.
  bit m_valid = 1'b0;
  int m_id = 0;
  int m_credit = 0;
  int m_ptr = N - 1;

  function automatic int find_next(int from, logic [N-1:0] a);
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (from + k) % N;
      if (a[t]) return t;
    end
    return -1;
  endfunction

  function automatic int quota(logic [N*WW-1:0] w, int t);
    int v;
    v = int'((w >> (t * WW)) & ((1 << WW) - 1));
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    bit rst_cycle;
    bit locked;
    int nxt;
    rst_cycle = 1'b0;
    locked    = 1'b0;
`ifdef ARASHI_ARB_LOCK_EN
    locked = lock;
`endif
    if (!rstn) begin
      m_valid = 1'b0; m_id = 0; m_credit = 0; m_ptr = N - 1;
      rst_cycle = 1'b1;
    end else if (!m_valid) begin
      nxt = find_next(m_ptr, avail);
      if (nxt >= 0) begin
        m_valid = 1'b1; m_id = nxt; m_credit = quota(weight, nxt);
      end
    end else if (gnt_ready && !locked) begin
      if (m_credit > 1 && avail[m_id]) begin
        m_credit = m_credit - 1;
      end else begin
        m_ptr = m_id;
        nxt = find_next(m_id, avail);
        if (nxt >= 0) begin
          m_id = nxt; m_credit = quota(weight, nxt);
        end else begin
          m_valid = 1'b0; m_credit = 0;
        end
      end
    end
    exp_q.push_back('{valid: m_valid, id: m_id, last: (m_valid && m_credit == 1),
                      cmp_id: (m_valid || rst_cycle)});
  endtask

  // Drive one cycle of inputs at the falling edge and record what the DUT must show next.
  task automatic cyc(input bit r, input logic [N-1:0] a, input logic [N*WW-1:0] w,
                     input bit rdy, input bit lk);
    @(negedge clk);
    rstn = r; avail = a; weight = w; gnt_ready = rdy;
`ifdef ARASHI_ARB_LOCK_EN
    lock = lk;
`else
    if (lk) rstn = r;
`endif
    model_step();
  endtask

  // Monitor: compare every registered output against the scoreboard and log accepted beats.
  bit            p_valid = 1'b0;
  logic [TW-1:0] p_id = '0;
  bit            p_last = 1'b0;
  int            log_id[$];
  bit            log_last[$];

  always @(posedge clk) begin
    #1;
    if (p_valid && gnt_ready && rstn) begin
      log_id.push_back(int'(p_id));
      log_last.push_back(p_last);
    end
    p_valid = gnt_valid;
    p_id    = gnt_id;
    p_last  = gnt_last;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt_valid !== e.valid || gnt_last !== e.last ||
          (e.cmp_id && gnt_id !== e.id[TW-1:0])) begin
        errors++;
        $display("FAIL outputs t=%0t: got valid=%0b id=%0d last=%0b, expected valid=%0b id=%0d last=%0b",
                 $time, gnt_valid, gnt_id, gnt_last, e.valid, e.id, e.last);
      end
    end
  end

  task automatic check_log(input string name, input int n, input int ids[8], input bit lasts[8]);
    @(posedge clk);
    #2;
    checks++;
    if (log_id.size() < n) begin
      errors++;
      $display("FAIL %s beat count: got %0d, expected at least %0d", name, log_id.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (log_id[i] != ids[i] || log_last[i] != lasts[i]) begin
          errors++;
          $display("FAIL %s beat %0d: got id=%0d last=%0b, expected id=%0d last=%0b",
                   name, i, log_id[i], log_last[i], ids[i], lasts[i]);
        end
      end
    end
  endtask

  task automatic reset_and_clear();
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    log_id.delete();
    log_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // All four threads, quota 1 each: plain rotation.
    reset_and_clear();
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0);
    check_log("rotate", 5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0, 0, 0});

    // Uneven weights between threads 0 and 2.
    reset_and_clear();
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b0101, 16'h0203, 1'b1, 1'b0);
    check_log("weighted", 6, '{0, 0, 0, 2, 2, 0, 0, 0}, '{0, 0, 1, 0, 1, 0, 0, 0});

    // Stalled grant survives its requester dropping; ends on the accept and moves on.
    reset_and_clear();
    cyc(1'b1, 4'b0010, 16'h0020, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1001, 16'h0020, 1'b0, 1'b0);
    cyc(1'b1, 4'b1001, 16'h0020, 1'b1, 1'b0);
    cyc(1'b1, 4'b1001, 16'h0020, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 16'h0020, 1'b0, 1'b0);
    check_log("stall", 2, '{1, 3, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});

    // Single requester with weight 0 is re-granted every beat, then goes idle.
    reset_and_clear();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1000, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0);
    check_log("single", 4, '{3, 3, 3, 3, 0, 0, 0, 0}, '{1, 1, 1, 1, 0, 0, 0, 0});

    // Reset in the middle of a grant to thread 2, then regrant after release.
    reset_and_clear();
    cyc(1'b1, 4'b0100, 16'h0200, 1'b1, 1'b0);
    cyc(1'b1, 4'b0100, 16'h0200, 1'b1, 1'b0);
    cyc(1'b0, 4'b0100, 16'h0200, 1'b1, 1'b0);
    log_id.delete();
    log_last.delete();
    cyc(1'b1, 4'b0100, 16'h0200, 1'b1, 1'b0);
    cyc(1'b1, 4'b0100, 16'h0200, 1'b1, 1'b0);
    check_log("post_reset", 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

`ifdef ARASHI_ARB_LOCK_EN
    // Lock pins thread 1 for several accepts; releasing it hands over to thread 2.
    reset_and_clear();
    cyc(1'b1, 4'b0110, 16'h0010, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0110, 16'h0010, 1'b1, 1'b1);
    cyc(1'b1, 4'b0110, 16'h0010, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 16'h0010, 1'b1, 1'b0);
    check_log("lock", 7, '{1, 1, 1, 1, 1, 1, 2, 0}, '{1, 1, 1, 1, 1, 1, 1, 0});
`endif

    // Random traffic: mostly-held weights, bursty requests, stalls and rare resets.
    begin
      logic [N*WW-1:0] w;
      logic [N-1:0]    a;
      w = N*WW'($urandom);
      a = N'($urandom);
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) w = N*WW'($urandom);
        if ($urandom_range(0, 3) == 0) a = N'($urandom);
        cyc(($urandom_range(0, 79) != 0), a, w, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0));
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
